// File: rtl/rot_rng_pkg.sv
// Shared Root-of-Trust RNG definitions: controller state encoding, health-check
// reject reasons, datapath width and the default timing used across RoT blocks.
package rot_rng_pkg;

    localparam int RNG_WIDTH             = 128;
    localparam int DEFAULT_WARMUP_CYCLES = 16;
    localparam int DEFAULT_RETRY_GAP     = 8;
    localparam int DEFAULT_MAX_RETRIES   = 3;
    localparam int FAIL_COUNT_WIDTH      = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DELIVER = 3'd4,
        ST_GAP     = 3'd5,
        ST_FAIL    = 3'd6
    } key_ctrl_state_e;

    typedef enum logic [1:0] {
        HC_OK       = 2'd0,
        HC_ALL_ZERO = 2'd1,
        HC_ALL_ONES = 2'd2,
        HC_REPEAT   = 2'd3
    } health_reason_e;

    // Number of bits needed to hold any value in 0..max_val (never less than one).
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rng_health_check.sv
// Combinational health test on one RNG sample: rejects stuck-at-zero,
// stuck-at-one and a repeat of the previously delivered key.
module rng_health_check
    import rot_rng_pkg::*;
#(
    parameter int WIDTH = RNG_WIDTH
)(
    input  logic [WIDTH-1:0] sample_i,
    input  logic [WIDTH-1:0] last_key_i,
    output logic             pass_o,
    output logic [1:0]       reason_o
);

    health_reason_e reason;

    // Classify the sample; the first matching rule is the reported reason.
    always_comb begin
        // NOTE: default assigned first so every path drives reason -> no latch.
        reason = HC_OK;
        if (sample_i == '0) begin
            reason = HC_ALL_ZERO;
        end else if (sample_i == '1) begin
            reason = HC_ALL_ONES;
        end else if (sample_i == last_key_i) begin
            reason = HC_REPEAT;
        end
    end

    assign pass_o   = (reason == HC_OK);
    assign reason_o = reason;

endmodule

// File: rtl/rng_key_controller.sv
// Key-generation sequencer for the RoT RNG: warm-up, sample, health check,
// bounded retry with a resample gap, valid/ready key hand-off and a sticky
// health alarm. All outputs come straight from registers.
module rng_key_controller
    import rot_rng_pkg::*;
#(
    parameter int WIDTH         = RNG_WIDTH,
    parameter int WARMUP_CYCLES = DEFAULT_WARMUP_CYCLES,
    parameter int RETRY_GAP     = DEFAULT_RETRY_GAP,
    parameter int MAX_RETRIES   = DEFAULT_MAX_RETRIES
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic [WIDTH-1:0]            rng_data,
    output logic                        rng_enable,
    output logic [WIDTH-1:0]            key_out,
    output logic                        key_valid,
    input  logic                        key_ready,
    output logic                        busy,
    output logic                        health_fail,
    output logic [FAIL_COUNT_WIDTH-1:0] fail_count
);

    // One down-counter serves both the warm-up and the retry gap.
    localparam int CNT_MAX = (WARMUP_CYCLES > RETRY_GAP) ? (WARMUP_CYCLES - 1) : (RETRY_GAP - 1);
    localparam int CNT_W   = count_width(CNT_MAX);
    localparam int RETRY_W = count_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0]   WARMUP_LOAD = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD    = CNT_W'(RETRY_GAP - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
    localparam logic [FAIL_COUNT_WIDTH-1:0] FAIL_COUNT_MAX = '1;

    key_ctrl_state_e             state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [RETRY_W-1:0]          retry_q;
    logic [WIDTH-1:0]            sample_q;
    logic [WIDTH-1:0]            last_key_q;
    logic [WIDTH-1:0]            key_out_q;
    logic                        key_valid_q;
    logic                        rng_enable_q;
    logic                        busy_q;
    logic                        health_fail_q;
    logic [FAIL_COUNT_WIDTH-1:0] fail_count_q;
    logic [FAIL_COUNT_WIDTH-1:0] fail_count_d;

    logic       hc_pass;
    logic [1:0] hc_reason;

    rng_health_check #(
        .WIDTH (WIDTH)
    ) u_health_check (
        .sample_i   (sample_q),
        .last_key_i (last_key_q),
        .pass_o     (hc_pass),
        .reason_o   (hc_reason)
    );

    // Saturating increment of the rejected-sample counter.
    always_comb begin
        fail_count_d = fail_count_q;
        if (fail_count_q != FAIL_COUNT_MAX) begin
            fail_count_d = fail_count_q + FAIL_COUNT_WIDTH'(1);
        end
    end

    // Pass flag and reject reason from the checker must tell the same story.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_CHECK) begin
            assert (hc_pass == (hc_reason == HC_OK));
        end
    end

    // Controller FSM with its counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide sample/last_key registers are reset too, so the
            // repetition test compares against a defined value after reset.
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            retry_q       <= '0;
            sample_q      <= '0;
            last_key_q    <= '0;
            key_out_q     <= '0;
            key_valid_q   <= 1'b0;
            rng_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            health_fail_q <= 1'b0;
            fail_count_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every branch reads pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q      <= ST_WARMUP;
                        cnt_q        <= WARMUP_LOAD;
                        rng_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end

                ST_WARMUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    sample_q <= rng_data;
                    state_q  <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (hc_pass) begin
                        state_q     <= ST_DELIVER;
                        key_out_q   <= sample_q;
                        key_valid_q <= 1'b1;
                    end else begin
                        fail_count_q <= fail_count_d;
                        if (retry_q == RETRY_LIMIT) begin
                            // Retry budget exhausted: park in FAIL with the RNG off.
                            state_q       <= ST_FAIL;
                            health_fail_q <= 1'b1;
                            rng_enable_q  <= 1'b0;
                            busy_q        <= 1'b0;
                        end else begin
                            retry_q <= retry_q + RETRY_W'(1);
                            cnt_q   <= GAP_LOAD;
                            state_q <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_DELIVER: begin
                    // key_out/key_valid simply hold until the consumer accepts.
                    if (key_ready) begin
                        last_key_q   <= sample_q;
                        sample_q     <= '0;
                        retry_q      <= '0;
                        key_out_q    <= '0;
                        key_valid_q  <= 1'b0;
                        rng_enable_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end

                ST_FAIL: begin
                    // Sticky: only rst leaves this state.
                    state_q <= ST_FAIL;
                end

                default: begin
                    state_q      <= ST_IDLE;
                    key_out_q    <= '0;
                    key_valid_q  <= 1'b0;
                    rng_enable_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign rng_enable  = rng_enable_q;
    assign key_out     = key_out_q;
    assign key_valid   = key_valid_q;
    assign busy        = busy_q;
    assign health_fail = health_fail_q;
    assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_rng_key_controller.sv
// Randomised scoreboard bench for rng_key_controller. The RNG is modelled by
// presenting scheduled candidate values on the edges where the controller is
// expected to sample; every other edge carries random junk.
module tb_rng_key_controller;

    localparam int WIDTH = 128;
    localparam int WARM  = 16;
    localparam int RGAP  = 8;
    localparam int MAXR  = 3;

    localparam int P_FIXED           = 0;
    localparam int P_FIXED_THEN_RAND = 1;
    localparam int P_RANDOM          = 2;
    localparam int P_SAT             = 3;
    localparam int P_STUCK           = 4;
    localparam int P_GOOD            = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic             key_ready;
    logic [WIDTH-1:0] rng_data;
    logic [WIDTH-1:0] key_out;
    logic             rng_enable;
    logic             key_valid;
    logic             busy;
    logic             health_fail;
    logic [7:0]       fail_count;

    rng_key_controller #(
        .WIDTH         (WIDTH),
        .WARMUP_CYCLES (WARM),
        .RETRY_GAP     (RGAP),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rng_data    (rng_data),
        .rng_enable  (rng_enable),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .busy        (busy),
        .health_fail (health_fail),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;   // number of rising edges seen so far

    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] key;
        int               vis_edge;   // edge at which key_valid must first be seen
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] sched [int];    // edge number -> value the RNG presents

    // Reference model state
    logic [WIDTH-1:0] last_key_m = '0;
    int               fail_cnt_m = 0;
    logic [WIDTH-1:0] fixed_val  = '0;

    // Consumer model controls
    bit ready_random      = 1'b0;
    int ready_block_until = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [WIDTH-1:0] bad_word();
        case ($urandom_range(0, 2))
            0:       return '0;
            1:       return '1;
            default: return last_key_m;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pick(input int pattern, input int k);
        case (pattern)
            P_FIXED:           return fixed_val;
            P_FIXED_THEN_RAND: return (k == 0) ? fixed_val : rand_word();
            P_SAT:             return (k < MAXR) ? bad_word() : rand_word();
            P_STUCK:           return '0;
            P_GOOD:            return rand_word();
            default:           return ($urandom_range(0, 9) < 7) ? rand_word() : bad_word();
        endcase
    endfunction

    // RNG model: scheduled value on sample edges, junk elsewhere.
    always @(posedge clk) begin
        #1;
        if (sched.exists(cyc + 1)) rng_data = sched[cyc + 1];
        else                       rng_data = rand_word();
    end

    // Consumer model: ready held low while blocked, otherwise steady or random.
    always @(posedge clk) begin
        #1;
        if (cyc + 1 < ready_block_until) key_ready = 1'b0;
        else if (ready_random)           key_ready = 1'($urandom_range(0, 1));
        else                             key_ready = 1'b1;
    end

    // Monitor: pops the scoreboard on each new key and follows it to transfer.
    exp_t cur;
    bit   in_dlv         = 1'b0;
    bit   post_xfer      = 1'b0;
    bit   spurious       = 1'b0;
    int   xfers          = 0;
    int   last_xfer_edge = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_dlv    = 1'b0;
            post_xfer = 1'b0;
            spurious  = 1'b0;
        end else begin
            if (post_xfer) begin
                check("post_xfer_valid", key_valid, 1'b0);
                check("post_xfer_key", key_out, '0);
                check("post_xfer_enable", rng_enable, 1'b0);
                post_xfer = 1'b0;
            end
            if (key_valid) begin
                if (!in_dlv && !spurious) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_key_valid", key_valid, 1'b0);
                        spurious = 1'b1;
                    end else begin
                        cur    = exp_q.pop_front();
                        in_dlv = 1'b1;
                        check("key_valid_latency", cyc + 1, cur.vis_edge);
                    end
                end
                if (in_dlv) begin
                    check("key_out_value", key_out, cur.key);
                    if (key_ready) begin
                        in_dlv         = 1'b0;
                        post_xfer      = 1'b1;
                        xfers++;
                        last_xfer_edge = cyc + 1;
                    end
                end
            end else begin
                if (in_dlv) begin
                    check("key_valid_dropped", key_valid, 1'b1);
                    in_dlv = 1'b0;
                end
                spurious = 1'b0;
                check("key_out_zero_when_invalid", key_out, '0);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        last_key_m        = '0;
        fail_cnt_m        = 0;
        ready_block_until = 0;
        check("rst_key_out", key_out, '0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_rng_enable", rng_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_health_fail", health_fail, 1'b0);
        check("rst_fail_count", fail_count, 8'd0);
    endtask

    // Issue one request and predict its outcome from the health rules.
    task automatic issue_request(input int pattern, input bit extra_req, input int block,
                                 output bit ok, output int s);
        int               n_edge;
        logic [WIDTH-1:0] cand;
        @(posedge clk); #1;
        check("idle_rng_enable", rng_enable, 1'b0);
        check("idle_busy", busy, 1'b0);
        req    = 1'b1;
        n_edge = cyc + 1;
        @(posedge clk); #1;
        req = 1'b0;
        check("warmup_rng_enable", rng_enable, 1'b1);
        check("warmup_busy", busy, 1'b1);
        ok = 1'b0;
        s  = 0;
        cand = '0;
        for (int k = 0; k <= MAXR; k++) begin
            s    = n_edge + WARM + 1 + k * (RGAP + 2);
            cand = pick(pattern, k);
            sched[s] = cand;
            if (cand == '0 || cand == '1 || cand == last_key_m) begin
                if (fail_cnt_m < 255) fail_cnt_m++;
            end else begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back('{key: cand, vis_edge: s + 2});
            ready_block_until = s + 2 + block;
            last_key_m        = cand;
        end
        if (extra_req) begin
            repeat (2) @(posedge clk);
            #1;
            req = 1'b1;
            check("busy_during_extra_req", busy, 1'b1);
            @(posedge clk); #1;
            req = 1'b0;
        end
    endtask

    task automatic finish_request(input bit ok, input int s);
        int target;
        int guard;
        if (ok) begin
            target = xfers + 1;
            guard  = 0;
            while (xfers < target && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (xfers < target) check("transfer_timeout", xfers, target);
            @(negedge clk);
            check("fail_count_after_key", fail_count, fail_cnt_m);
            check("health_fail_clear", health_fail, 1'b0);
        end else begin
            while (cyc < s + 1) begin
                @(posedge clk); #1;
            end
            check("fail_health_fail", health_fail, 1'b1);
            check("fail_rng_enable", rng_enable, 1'b0);
            check("fail_busy", busy, 1'b0);
            check("fail_key_valid", key_valid, 1'b0);
            check("fail_fail_count", fail_count, fail_cnt_m);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int s;
        int x0;
        rst       = 1'b1;
        req       = 1'b0;
        key_ready = 1'b0;
        rng_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_key_out", key_out, '0);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_rng_enable", rng_enable, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_health_fail", health_fail, 1'b0);
        check("reset_fail_count", fail_count, 8'd0);

        // Basic: req sampled at edge 10, key seen at edge 29
        while (cyc < 8) begin
            @(posedge clk); #1;
        end
        fixed_val = 128'h0123456789ABCDEF0123456789ABCDEF;
        issue_request(P_FIXED, 1'b0, 0, ok, s);
        finish_request(ok, s);

        // Backpressure: ready held low 20 cycles while rng_data churns
        issue_request(P_GOOD, 1'b0, 20, ok, s);
        finish_request(ok, s);
        check("backpressure_xfer_edge", last_xfer_edge, s + 2 + 20);

        // Repetition: identical data on two requests
        fixed_val = {16{8'hA5}};
        issue_request(P_FIXED, 1'b0, 0, ok, s);
        finish_request(ok, s);
        issue_request(P_FIXED_THEN_RAND, 1'b0, 0, ok, s);
        finish_request(ok, s);

        // Stuck RNG: four rejects raise the alarm; req then ignored
        apply_reset();
        issue_request(P_STUCK, 1'b0, 0, ok, s);
        finish_request(ok, s);
        @(posedge clk); #1;
        req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fail_req_ignored_enable", rng_enable, 1'b0);
        check("fail_req_ignored_busy", busy, 1'b0);
        check("fail_sticky_alarm", health_fail, 1'b1);
        check("fail_count_stuck", fail_count, 8'd4);
        apply_reset();

        // Reset during warm-up
        @(posedge clk); #1;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("warmup_busy_before_rst", busy, 1'b1);
        apply_reset();

        // Reset during delivery: key dropped, no handshake
        issue_request(P_GOOD, 1'b0, 1000, ok, s);
        while (cyc < s + 2) begin
            @(posedge clk); #1;
        end
        check("deliver_valid_before_rst", key_valid, 1'b1);
        x0 = xfers;
        apply_reset();
        @(negedge clk);
        check("deliver_rst_no_xfer", xfers, x0);

        // Random traffic with stray req and ready pulses
        ready_random = 1'b1;
        for (int i = 0; i < 25; i++) begin
            issue_request(P_RANDOM, 1'($urandom_range(0, 1)), $urandom_range(0, 4), ok, s);
            finish_request(ok, s);
            if (!ok) apply_reset();
        end

        // Drive the reject counter into saturation
        ready_random = 1'b0;
        apply_reset();
        for (int i = 0; i < 90; i++) begin
            issue_request(P_SAT, 1'b0, 0, ok, s);
            finish_request(ok, s);
        end
        check("fail_count_saturated", fail_count, 8'd255);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
